// File: rtl/dmem_lane_if.sv
// dmem_lane_if: request/response bundle between the EX/MEM stage and dmem_lane.
//   master modport (processor side): drives memEn, wrEn, memAddr, dataIn, laneMask;
//                                    observes ready, rdValid, dataOut, parityErr.
//   slave modport (memory side):     the mirror image.
// Bit 0 of memAddr, dataIn, laneMask and dataOut is the MSB. Lane i of a data word
// covers bits [i*LANE_W : i*LANE_W+LANE_W-1].
interface dmem_lane_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned LANES = DATA_W / LANE_W;

    logic              memEn;
    logic              wrEn;
    logic [0:ADDR_W-1] memAddr;
    logic [0:DATA_W-1] dataIn;
    logic [0:LANES-1]  laneMask;
    logic              ready;
    logic              rdValid;
    logic [0:DATA_W-1] dataOut;
    logic              parityErr;

    modport master (
        output memEn, wrEn, memAddr, dataIn, laneMask,
        input  ready, rdValid, dataOut, parityErr
    );

    modport slave (
        input  memEn, wrEn, memAddr, dataIn, laneMask,
        output ready, rdValid, dataOut, parityErr
    );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: parametrised wide-word data memory with per-lane write masking,
// a post-reset clear sweep and one-cycle read latency from a registered address.
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset (restarts the clear sweep)
//   bus   : dmem_lane_if.slave -- request (memEn/wrEn/memAddr/dataIn/laneMask)
//           and response (ready/rdValid/dataOut/parityErr)
// Optional feature: define DMEM_PARITY_EN to store one even-parity bit per lane
// and flag mismatches on reads; otherwise parityErr is tied low.
module dmem_lane #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_lane_if.slave  bus
);
    localparam int unsigned     LANES     = DATA_W / LANE_W;
    localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              r_mem_en_q, r_mem_en_d;
    logic [ADDR_W-1:0] r_mem_addr_q, r_mem_addr_d;
    logic              rd_valid_q, rd_valid_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [0:DATA_W-1] mem_wdata_c;
    logic [0:LANES-1]  mem_wmask_c;
    logic              req_in_range_c;

    logic [0:DATA_W-1] mem_q [DEPTH];

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            r_mem_en_q   <= 1'b0;
            r_mem_addr_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            r_mem_en_q   <= r_mem_en_d;
            r_mem_addr_q <= r_mem_addr_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign req_in_range_c = {1'b0, bus.memAddr} < DEPTH_X;

    // Next state: clear sweep, then accept one access per cycle
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        r_mem_en_d   = 1'b0;
        r_mem_addr_d = r_mem_addr_q;
        rd_valid_d   = 1'b0;
        mem_we_c     = 1'b0;
        mem_waddr_c  = clr_addr_q;
        mem_wdata_c  = '0;
        mem_wmask_c  = '1;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.memEn) begin
                    r_mem_en_d   = 1'b1;
                    r_mem_addr_d = bus.memAddr;
                    rd_valid_d   = ~bus.wrEn;
                    // out-of-range writes are silently dropped
                    if (bus.wrEn && req_in_range_c) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = bus.memAddr;
                        mem_wdata_c = bus.dataIn;
                        mem_wmask_c = bus.laneMask;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Storage write port, lane-masked
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (mem_wmask_c[i]) begin
                    mem_q[mem_waddr_c][i*LANE_W +: LANE_W] <= mem_wdata_c[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read path: registered address, storage read asynchronously so a
    // write is echoed in the following cycle
    logic              rd_hit_c;
    logic [0:DATA_W-1] rd_word_c;

    assign rd_hit_c  = r_mem_en_q && ({1'b0, r_mem_addr_q} < DEPTH_X);
    assign rd_word_c = mem_q[r_mem_addr_q];

    assign bus.ready   = (state_q == ST_RUN);
    assign bus.rdValid = rd_valid_q;
    assign bus.dataOut = rd_hit_c ? rd_word_c : '0;

`ifdef DMEM_PARITY_EN
    logic [0:LANES-1] par_q [DEPTH];
    logic [0:LANES-1] par_mis_c;

    // Even parity per lane, written with the same lane mask as the data
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (mem_wmask_c[i]) begin
                    par_q[mem_waddr_c][i] <= ^mem_wdata_c[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        par_mis_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            par_mis_c[i] = (^rd_word_c[i*LANE_W +: LANE_W]) ^ par_q[r_mem_addr_q][i];
        end
    end

    // out-of-range reads never flag an error
    assign bus.parityErr = rd_valid_q & rd_hit_c & (|par_mis_c);
`else
    assign bus.parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lane.sv
// tb_dmem_lane: randomized and directed stimulus for dmem_lane, checked every
// cycle against a word-array reference model kept in the bench.
module tb_dmem_lane;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LANES  = DATA_W / LANE_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lane_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();

    dmem_lane #(
        .DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [127:0] model [DEPTH];
    int           edges_since_rel;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Assert reset asynchronously, check reset state, release away from an edge.
    task automatic do_reset(input logic en);
        bus.memEn    = en;
        bus.wrEn     = 1'b0;
        bus.memAddr  = '0;
        bus.dataIn   = '0;
        bus.laneMask = '0;
        rst_n = 1'b0;
        #1;
        check("rst_ready",   128'(bus.ready),     128'd0);
        check("rst_rdValid", 128'(bus.rdValid),   128'd0);
        check("rst_dataOut", 128'(bus.dataOut),   128'd0);
        check("rst_parity",  128'(bus.parityErr), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges_since_rel = 0;
        for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;
    endtask

    // One bus cycle: drive request, take the edge, update model, check outputs.
    task automatic cyc(input logic en, input logic wr, input logic [7:0] addr,
                       input logic [127:0] d, input logic [15:0] m, input logic exp_perr);
        logic         acc;
        logic         exp_v;
        logic [127:0] exp_d;
        bus.memEn    = en;
        bus.wrEn     = wr;
        bus.memAddr  = addr;
        bus.dataIn   = d;
        bus.laneMask = m;
        @(posedge clk);
        acc = en && (edges_since_rel >= int'(DEPTH));
        edges_since_rel++;
        exp_v = 1'b0;
        exp_d = '0;
        if (acc) begin
            if (wr) begin
                // mask MSB selects lane 0, which is the most significant byte
                for (int i = 0; i < int'(LANES); i++) begin
                    if (m[15-i]) model[addr][127-8*i -: 8] = d[127-8*i -: 8];
                end
            end
            exp_v = !wr;
            exp_d = model[addr];
        end
        #1;
        check("ready",     128'(bus.ready),     128'(edges_since_rel >= int'(DEPTH)));
        check("rdValid",   128'(bus.rdValid),   128'(exp_v));
        check("dataOut",   128'(bus.dataOut),   exp_d);
        check("parityErr", 128'(bus.parityErr), 128'(exp_v & exp_perr));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, '0, '0, 1'b0);
    endtask

    initial begin
        logic [127:0] v2;
        v2 = 128'h00112233445566778899AABBCCDDEEFF;

        // Clear sweep with memEn held high, then read the last word
        do_reset(1'b1);
        for (int k = 0; k < int'(DEPTH); k++) cyc(1'b1, 1'b0, 8'hFF, '0, '0, 1'b0);
        cyc(1'b1, 1'b0, 8'hFF, '0, '0, 1'b0);
        idle_cycles(1);

        // Full write then read back
        cyc(1'b1, 1'b1, 8'h10, v2, 16'hFFFF, 1'b0);
        cyc(1'b1, 1'b0, 8'h10, '0, '0, 1'b0);
        check("t2_value", 128'(bus.dataOut), v2);

        // Edge lanes only
        cyc(1'b1, 1'b1, 8'h10, '1, 16'h8001, 1'b0);
        cyc(1'b1, 1'b0, 8'h10, '0, '0, 1'b0);
        check("t3_value", 128'(bus.dataOut), 128'hFF112233445566778899AABBCCDDEEFF);

        // No-op write with empty mask
        cyc(1'b1, 1'b1, 8'h10, '0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 8'h10, '0, '0, 1'b0);

        // Alternating write/read, no bubbles
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 8'h20, rand_word(), 16'hFFFF, 1'b0);
            cyc(1'b1, 1'b0, 8'h20, '0, '0, 1'b0);
        end

        // Reset mid-sweep restarts the clear
        do_reset(1'b0);
        idle_cycles(100);
        do_reset(1'b0);
        for (int k = 0; k < int'(DEPTH) - 1; k++) cyc(1'b1, 1'b0, 8'h10, '0, '0, 1'b0);
        idle_cycles(1);
        cyc(1'b1, 1'b0, 8'h10, '0, '0, 1'b0);
        check("t5_cleared", 128'(bus.dataOut), 128'd0);

`ifdef DMEM_PARITY_EN
        // Corrupt one stored bit of lane 3 and expect a parity flag
        cyc(1'b1, 1'b1, 8'h30, rand_word(), 16'hFFFF, 1'b0);
        dut.mem_q[8'h30][24] = ~dut.mem_q[8'h30][24];
        model[8'h30][127-24] = ~model[8'h30][127-24];
        cyc(1'b1, 1'b0, 8'h30, '0, '0, 1'b1);
        cyc(1'b1, 1'b1, 8'h30, rand_word(), 16'hFFFF, 1'b0);
        cyc(1'b1, 1'b0, 8'h30, '0, '0, 1'b0);
`endif

        // Random traffic; addresses mostly in a small window to create hits
        for (int k = 0; k < 600; k++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h40 + $urandom_range(0, 7));
            cyc(($urandom_range(0, 3) != 0), 1'($urandom), a, rand_word(), 16'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
